uart_rx: RTL

Standalone UART receiver that deserializes the frames produced by the `uart_top` transmit path. It uses the same frame format: start bit 0, 8 data bits LSB-first, one parity bit, then 1 or 2 stop bits. It samples each bit at mid-period using a programmable baud divisor and presents each received byte on a valid/ready handshake with parity and framing status. It sits between the serial pin and the byte consumer, and is the receive-side counterpart used in loopback benches against the transmitter.

---
 rtl/uart_rx_if.sv | 34 +++
 rtl/uart_rx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Byte delivery channel of the UART receiver.
//   data_out  : received byte
//   valid_out : byte pending; held until accepted
//   ready_in  : consumer accepts on valid_out && ready_in
//   parity_ok : parity check result for data_out
//   frame_err : a stop bit of data_out was sampled low
//   overrun   : a frame was dropped because a byte was still pending
// The receiver uses the master modport; the byte consumer uses slave.
interface uart_rx_if;
  logic [7:0] data_out;
  logic       valid_out;
  logic       ready_in;
  logic       parity_ok;
  logic       frame_err;
  logic       overrun;

  modport master (
    output data_out,
    output valid_out,
    output parity_ok,
    output frame_err,
    output overrun,
    input  ready_in
  );

  modport slave (
    input  data_out,
    input  valid_out,
    input  parity_ok,
    input  frame_err,
    input  overrun,
    output ready_in
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start bit 0, 8 data bits LSB first, one parity bit, 1 or 2 stop bits.
// Bits are sampled mid-period; bit period is baud_divisor+1 clocks.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous active-low reset
//   rx_en        : receiver enable; low aborts any frame in progress
//   rx           : serial input, idle high, asynchronous to clk
//   parity_sel   : 0 = even, 1 = odd parity
//   stop_sel     : 0 = one stop bit, 1 = two stop bits
//   baud_divisor : bit period minus one (legal 3..4095)
//   busy         : receiver is inside a frame
//   out_if       : received byte with status, valid/ready handshake
module uart_rx (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_en,
  input  logic        rx,
  input  logic        parity_sel,
  input  logic        stop_sel,
  input  logic [11:0] baud_divisor,
  output logic        busy,
  uart_rx_if.master   out_if
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rxs_q;
  logic [11:0] cnt_q, cnt_d;
  logic [11:0] div_q, div_d;
  logic        psel_q, psel_d;
  logic        ssel_q, ssel_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        pok_q, pok_d;
  logic        stop_bad_q, stop_bad_d;

  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        parity_ok_q, parity_ok_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic        bit_end;
  logic        complete;
  logic        frame_ferr;
  logic        accept;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  assign bit_end = (cnt_q == div_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 12'd1;
    div_d      = div_q;
    psel_d     = psel_q;
    ssel_d     = ssel_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    pok_d      = pok_q;
    stop_bad_d = stop_bad_q;
    complete   = 1'b0;
    frame_ferr = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = 12'd0;
        if (!rxs_q) begin
          state_d = StStart;
          // Frame configuration is frozen for the whole frame.
          div_d   = baud_divisor;
          psel_d  = parity_sel;
          ssel_d  = stop_sel;
        end
      end
      StStart: begin
        if (cnt_q == (div_q >> 1)) begin
          if (rxs_q) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            cnt_d   = 12'd0;
            idx_d   = 3'd0;
          end
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d   = 12'd0;
          shift_d = {rxs_q, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = StParity;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          cnt_d      = 12'd0;
          pok_d      = ((^shift_q) ^ rxs_q) == psel_q;
          stop_bad_d = 1'b0;
          state_d    = StStop1;
        end
      end
      StStop1: begin
        if (bit_end) begin
          cnt_d      = 12'd0;
          stop_bad_d = ~rxs_q;
          if (ssel_q) begin
            state_d = StStop2;
          end else begin
            state_d    = StIdle;
            complete   = 1'b1;
            frame_ferr = ~rxs_q;
          end
        end
      end
      StStop2: begin
        if (bit_end) begin
          cnt_d      = 12'd0;
          state_d    = StIdle;
          complete   = 1'b1;
          frame_ferr = stop_bad_q | ~rxs_q;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Disable wins over everything and discards the partial frame.
    if (!rx_en) begin
      state_d  = StIdle;
      complete = 1'b0;
    end
  end

  assign accept = valid_q & out_if.ready_in;

  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    parity_ok_d = parity_ok_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (accept) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    // An accept on the completion edge frees the slot for the new byte.
    if (complete) begin
      if (!valid_q || accept) begin
        data_d      = shift_q;
        parity_ok_d = pok_q;
        frame_err_d = frame_ferr;
        valid_d     = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= 12'd0;
      div_q       <= 12'd0;
      psel_q      <= 1'b0;
      ssel_q      <= 1'b0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      pok_q       <= 1'b0;
      stop_bad_q  <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      parity_ok_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      psel_q      <= psel_d;
      ssel_q      <= ssel_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      pok_q       <= pok_d;
      stop_bad_q  <= stop_bad_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      parity_ok_q <= parity_ok_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy             = (state_q != StIdle);
  assign out_if.data_out  = data_q;
  assign out_if.valid_out = valid_q;
  assign out_if.parity_ok = parity_ok_q;
  assign out_if.frame_err = frame_err_q;
  assign out_if.overrun   = overrun_q;

endmodule
